// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM state codes and op helpers
// for the MultDiv engine.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-side bundle of the MultDiv engine: issue, moves,
// HI/LO readout and stall.
interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              mthi;
  logic              mtlo;
  logic              mf_req;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;
  logic              stall;

  modport master (
    output start, op, rs_data, rt_data,
    output mthi, mtlo, mf_req,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    input  mthi, mtlo, mf_req,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mdu_shift_core.sv
// Radix-2 datapath: shift-add multiply and restoring
// shift-subtract divide on unsigned magnitudes.
module mdu_shift_core
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic                div,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] acc,
  output logic [DATA_W-1:0]   quo,
  output logic                last
);

  logic [CNT_W-1:0] cnt;
  logic [DATA_W:0]  madd;
  logic [DATA_W:0]  shl;
  logic [DATA_W+1:0] diff;
  logic             ge;

  // Upper half holds partial product or remainder,
  // lower half the multiplier or remaining dividend bits.
  always_comb begin
    madd = {1'b0, acc[2*DATA_W-1:DATA_W]}
         + {1'b0, b & {DATA_W{acc[0]}}};
    shl  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    diff = {1'b0, shl} - {2'b0, b};
    ge   = ~diff[DATA_W+1];
  end

  assign last = (cnt == CNT_W'(DATA_W-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      quo <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= {{DATA_W{1'b0}}, a};
      quo <= '0;
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
      if (div) begin
        acc <= {ge ? diff[DATA_W-1:0]
                   : shl[DATA_W-1:0],
                acc[DATA_W-2:0], 1'b0};
        quo <= {quo[DATA_W-2:0], ge};
      end else begin
        acc <= {madd, acc[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO
// registers and MFHI/MFLO stall generation.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  mult_div_unit_if.slave   bus
);

  logic [1:0]          state;
  logic [1:0]          op_q;
  logic                sa, sb, dz;
  logic [DATA_W-1:0]   rs_q;
  logic [DATA_W-1:0]   hi_r, lo_r;
  logic                busy_r, done_r;
  logic                sgn;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] acc, prod;
  logic [DATA_W-1:0]   quo, quo_s, rem_s;
  logic                last;

  assign sgn   = op_is_signed(bus.op);
  assign a_mag = (sgn && bus.rs_data[DATA_W-1])
               ? -bus.rs_data : bus.rs_data;
  assign b_mag = (sgn && bus.rt_data[DATA_W-1])
               ? -bus.rt_data : bus.rt_data;

  mdu_shift_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (state == S_IDLE && bus.start),
    .step (state == S_CALC),
    .div  (op_is_div(op_q)),
    .a    (a_mag),
    .b    (b_mag),
    .acc  (acc),
    .quo  (quo),
    .last (last)
  );

  // Sign bits are latched as zero for unsigned ops.
  assign prod  = (sa ^ sb) ? -acc : acc;
  assign quo_s = (sa ^ sb) ? -quo : quo;
  assign rem_s = sa ? -acc[2*DATA_W-1:DATA_W]
                    : acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      op_q   <= OP_MULT;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      rs_q   <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            sa     <= sgn & bus.rs_data[DATA_W-1];
            sb     <= sgn & bus.rt_data[DATA_W-1];
            dz     <= op_is_div(bus.op)
                    && bus.rt_data == '0;
            rs_q   <= bus.rs_data;
            busy_r <= 1'b1;
            state  <= S_CALC;
          end else begin
            if (bus.mthi) hi_r <= bus.rs_data;
            if (bus.mtlo) lo_r <= bus.rs_data;
          end
        end
        S_CALC: begin
          if (last) state <= S_FIX;
        end
        S_FIX: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          if (!op_is_div(op_q)) begin
            hi_r <= prod[2*DATA_W-1:DATA_W];
            lo_r <= prod[DATA_W-1:0];
          end else if (dz) begin
            hi_r <= rs_q;
            lo_r <= '1;
          end else begin
            hi_r <= rem_s;
            lo_r <= quo_s;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.stall = bus.mf_req & busy_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus
// chained, stall, ownership and reset-abort sequences.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_div_unit_if #(.DATA_W(32)) bus ();

  mult_div_unit #(
    .DATA_W (32),
    .CNT_W  (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op,
                       input logic [31:0] rs,
                       input logic [31:0] rt,
                       output int lat,
                       output int dcyc);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    dcyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        dcyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 chk("done_width", bus.done, 1'b0);
  endtask

  initial begin
    int lat, dc, last_dc, dn, mingap, scnt;
    logic [31:0] acc;
    logic held;

    bus.start = 0; bus.op = 0;
    bus.rs_data = 0; bus.rt_data = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.mf_req = 1;

    vt[0] = '{"divu_40320", OP_DIVU, 32'd40320,
              32'd40320, 32'h0, 32'h1};
    vt[1] = '{"multu_max", OP_MULTU, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
    vt[2] = '{"div_m7_2", OP_DIV, 32'hFFFFFFF9,
              32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{"mult_m1_m1", OP_MULT, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'h0, 32'h1};
    vt[4] = '{"div_ovf", OP_DIV, 32'h80000000,
              32'hFFFFFFFF, 32'h0, 32'h80000000};
    vt[5] = '{"divu_5_0", OP_DIVU, 32'd5,
              32'd0, 32'd5, 32'hFFFFFFFF};
    vt[6] = '{"div_m7_0", OP_DIV, 32'hFFFFFFF9,
              32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[7] = '{"mult_m3_5", OP_MULT, 32'hFFFFFFFD,
              32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vt[8] = '{"div_7_m2", OP_DIV, 32'd7,
              32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    vt[9] = '{"multu_shift", OP_MULTU, 32'h12345678,
              32'h10, 32'h1, 32'h23456780};

    #12;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_stall", bus.stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.mf_req = 0;

    acc = 32'd1;
    dn = 0;
    last_dc = -1;
    mingap = 1000;
    for (int k = 2; k <= 8; k++) begin
      do_op(OP_MULTU, acc, k, lat, dc);
      acc = acc * k;
      chk("chain_lat", lat, 33);
      if (lat > 0) dn++;
      if (last_dc >= 0 && dc - last_dc < mingap)
        mingap = dc - last_dc;
      last_dc = dc;
    end
    chk("chain_lo", bus.lo, 32'd40320);
    chk("chain_hi", bus.hi, 32'd0);
    chk("chain_dones", dn, 7);
    chk("chain_gap", mingap >= 34, 1'b1);

    foreach (vt[i]) begin
      do_op(vt[i].op, vt[i].rs, vt[i].rt, lat, dc);
      chk({vt[i].name, "_lat"}, lat, 33);
      chk({vt[i].name, "_hi"}, bus.hi, vt[i].hi);
      chk({vt[i].name, "_lo"}, bus.lo, vt[i].lo);
    end

    @(negedge clk);
    bus.mthi = 1; bus.rs_data = 32'h1234;
    @(negedge clk);
    bus.mthi = 0; bus.mtlo = 1; bus.rs_data = 32'h5678;
    @(negedge clk);
    bus.mtlo = 0;
    chk("mthi", bus.hi, 32'h1234);
    chk("mtlo", bus.lo, 32'h5678);
    bus.mthi = 1; bus.mtlo = 1; bus.rs_data = 32'hABCD;
    @(negedge clk);
    bus.mthi = 0; bus.mtlo = 0;
    chk("mt_both_hi", bus.hi, 32'hABCD);
    chk("mt_both_lo", bus.lo, 32'hABCD);

    bus.start = 1; bus.mthi = 1; bus.op = OP_MULTU;
    bus.rs_data = 3; bus.rt_data = 4;
    @(posedge clk);
    #1 bus.start = 0; bus.mthi = 0;
    for (int i = 0; i < 40 && !bus.done; i++)
      @(posedge clk) #1;
    chk("start_wins_hi", bus.hi, 32'h0);
    chk("start_wins_lo", bus.lo, 32'd12);

    @(negedge clk);
    bus.mthi = 1; bus.mtlo = 1; bus.rs_data = 32'h1111;
    @(negedge clk);
    bus.mthi = 0; bus.mtlo = 0;
    bus.start = 1; bus.mf_req = 1; bus.op = OP_MULTU;
    bus.rs_data = 6; bus.rt_data = 7;
    @(posedge clk);
    #1 bus.start = 0;
    scnt = 0;
    held = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      scnt++;
      if (bus.hi !== 32'h1111 || bus.lo !== 32'h1111)
        held = 1'b0;
      if (i == 5) begin
        bus.start = 1; bus.mthi = 1; bus.op = OP_DIVU;
        bus.rs_data = 100; bus.rt_data = 3;
      end else begin
        bus.start = 0; bus.mthi = 0;
      end
    end
    bus.mf_req = 0;
    chk("stall_cycles", scnt, 33);
    chk("hold_in_calc", held, 1'b1);
    chk("busy_ign_hi", bus.hi, 32'h0);
    chk("busy_ign_lo", bus.lo, 32'd42);
    @(negedge clk);
    chk("no_queue_busy", bus.busy, 1'b0);

    bus.start = 1; bus.op = OP_MULT;
    bus.rs_data = 32'hFFFFFFFD; bus.rt_data = 5;
    @(posedge clk);
    #1 bus.start = 0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    do_op(OP_MULTU, 32'd9, 32'd9, lat, dc);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_hi", bus.hi, 32'h0);
    chk("post_rst_lo", bus.lo, 32'd81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
